// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write port shared by the in-order pipeline
// writeback and a multi-cycle unit (divider/load). Multi-cycle results are
// buffered in a small FIFO and drained into idle pipeline slots. A starvation
// counter forces a drain slot by stalling the pipeline for one cycle.
// Optional feature macro: WB_BYPASS_EN lets a multi-cycle result skip the
// empty buffer and go straight to the write port.
module wb_arbiter #(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 4,
  parameter int STARVE_LIMIT        = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pipe_we,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      pipe_rd,
  input  logic [DATA_WIDTH-1:0]               pipe_wd,
  input  logic                                mc_valid,
  output logic                                mc_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      mc_rd,
  input  logic [DATA_WIDTH-1:0]               mc_wd,
  output logic                                pipe_stall,
  output logic                                we3,
  output logic [REG_FILE_ADDR_WIDTH-1:0]      ad3,
  output logic [DATA_WIDTH-1:0]               wd3,
  output logic [2**REG_FILE_ADDR_WIDTH-1:0]   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

  logic [REG_FILE_ADDR_WIDTH-1:0] fifo_rd [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]          fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [STARVE_W-1:0]            starve_cnt;

  logic                           fifo_empty;
  logic                           fifo_full;
  logic                           pipe_slot;
  logic                           mc_fire;
  logic                           bypass;
  logic                           push;
  logic                           pop;
  logic                           starving;
  logic                           starve_hit;
  logic [REG_FILE_ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]          head_wd;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_wd    = fifo_wd[rd_ptr];

  // A pending bit blocks a second outstanding write to the same register,
  // so the buffer can never reorder two writes to one destination.
  assign mc_ready  = !fifo_full && !pending_mask[mc_rd];
  assign mc_fire   = mc_valid && mc_ready;

  // Writes to r0 are discarded, so such a pipeline slot is free for draining.
  assign pipe_slot = pipe_we && (pipe_rd != '0) && !pipe_stall;
  assign pop       = !pipe_slot && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !pipe_slot && !pipe_stall && mc_valid && (mc_rd != '0);
`else
  assign bypass = 1'b0;
`endif

  assign push       = mc_fire && (mc_rd != '0) && !bypass;
  assign starving   = !fifo_empty && !pop;
  assign starve_hit = starving && (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));

  // Buffer storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr] <= mc_rd;
      fifo_wd[wr_ptr] <= mc_wd;
    end
  end

  // Buffer pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Pending mask tracks which registers have a write waiting in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mask <= '0;
    end else begin
      if (pop)  pending_mask[head_rd] <= 1'b0;
      if (push) pending_mask[mc_rd]   <= 1'b1;
    end
  end

  // Starvation counter; on its last step it steals one pipeline slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else if (starve_hit) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b1;
    end else if (starving) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end
  end

  // Write-port registers: pipeline first, then buffer head, then bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ad3 <= '0;
      wd3 <= '0;
    end else if (pipe_slot) begin
      we3 <= 1'b1;
      ad3 <= pipe_rd;
      wd3 <= pipe_wd;
    end else if (!fifo_empty) begin
      we3 <= 1'b1;
      ad3 <= head_rd;
      wd3 <= head_wd;
    end else if (bypass) begin
      we3 <= 1'b1;
      ad3 <= mc_rd;
      wd3 <= mc_wd;
    end else begin
      we3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. A queue-based reference
// model predicts each register-file write; a monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int NREGS = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_we = 1'b0;
  logic [AW-1:0] pipe_rd = '0;
  logic [DW-1:0] pipe_wd = '0;
  logic          mc_valid = 1'b0;
  logic          mc_ready;
  logic [AW-1:0] mc_rd = '0;
  logic [DW-1:0] mc_wd = '0;
  logic          pipe_stall;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  logic [NREGS-1:0] pending_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_arbiter #(
    .REG_FILE_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_wd(mc_wd),
    .pipe_stall(pipe_stall), .we3(we3), .ad3(ad3), .wd3(wd3),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } entry_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } exp_t;

  entry_t mq[$];
  exp_t   expq[$];
  int     cyc = 0;
  bit     m_stall = 1'b0;
  int     m_streak = 0;
  bit     m_accepted = 1'b0;
  int     n_cmp = 0;
  int     n_fail = 0;

  function automatic bit is_pending(logic [AW-1:0] r);
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREGS-1:0] exp_mask();
    logic [NREGS-1:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic bit exp_ready(logic [AW-1:0] r);
    return (mq.size() < DEPTH) && !is_pending(r);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic driveInputs(input bit pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pwd,
                             input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mwd);
    pipe_we  = pwe;
    pipe_rd  = prd;
    pipe_wd  = pwd;
    mc_valid = mv;
    mc_rd    = mrd;
    mc_wd    = mwd;
  endtask

  task automatic applyStimulus(input bit pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pwd,
                               input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mwd);
    @(posedge clk);
    #1;
    driveInputs(pwe, prd, pwd, mv, mrd, mwd);
  endtask

  // Reference model: a write slot goes to the pipeline if it has a real
  // destination, otherwise to the oldest buffered result; each run of
  // LIMIT consecutive undrained edges earns one forced drain cycle.
  initial begin : model
    bit     empty, slot, fire, byp, pop, nstall;
    entry_t ent;
    exp_t   e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        expq.delete();
        m_stall    = 1'b0;
        m_streak   = 0;
        m_accepted = 1'b0;
      end else begin
        empty = (mq.size() == 0);
        slot  = pipe_we && (pipe_rd != 0) && !m_stall;
        fire  = mc_valid && exp_ready(mc_rd);
        byp   = BYPASS && empty && !slot && !m_stall && mc_valid && (mc_rd != 0);
        pop   = !slot && !empty;
        e.cyc = cyc + 1;
        if (slot) begin
          e.rd = pipe_rd; e.wd = pipe_wd; expq.push_back(e);
        end else if (!empty) begin
          e.rd = mq[0].rd; e.wd = mq[0].wd; expq.push_back(e);
        end else if (byp) begin
          e.rd = mc_rd; e.wd = mc_wd; expq.push_back(e);
        end
        nstall = 1'b0;
        if (empty || pop) m_streak = 0;
        else if (m_streak + 1 == LIMIT) begin m_streak = 0; nstall = 1'b1; end
        else m_streak = m_streak + 1;
        if (pop) void'(mq.pop_front());
        if (fire && (mc_rd != 0) && !byp) begin
          ent.rd = mc_rd; ent.wd = mc_wd; mq.push_back(ent);
        end
        m_stall    = nstall;
        m_accepted = fire;
      end
      cyc++;
    end
  end

  // Monitor: on each negedge compare the write port against the scoreboard
  // and the status outputs against the model state.
  initial begin : monitor
    logic [AW-1:0] last_ad;
    logic [DW-1:0] last_wd;
    bit            exp_we;
    exp_t          e;
    last_ad = '0;
    last_wd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_ad = '0;
        last_wd = '0;
      end else begin
        exp_we = (expq.size() > 0) && (expq[0].cyc == cyc);
        checkOutput("we3", 64'(we3), 64'(exp_we));
        if (exp_we) begin
          e = expq.pop_front();
          last_ad = e.rd;
          last_wd = e.wd;
        end
        checkOutput("ad3", 64'(ad3), 64'(last_ad));
        checkOutput("wd3", 64'(wd3), 64'(last_wd));
        checkOutput("pipe_stall", 64'(pipe_stall), 64'(m_stall));
        checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
        checkOutput("pending_mask", 64'(pending_mask), 64'(exp_mask()));
        checkOutput("mc_ready", 64'(mc_ready), 64'(exp_ready(mc_rd)));
      end
    end
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin : stimulus
    bit            pwe, mv;
    logic [AW-1:0] prd, mrd;
    logic [DW-1:0] pwd, mwd;
    int            pct;
    mv = 1'b0; mrd = '0; mwd = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Pipeline-only writes, then an r0 write that must not reach the port.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    applyStimulus(1, 0, 32'h12345678, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // Buffered result waits behind pipeline traffic, drains on first idle slot.
    applyStimulus(1, 10, 32'hA0, 1, 7, 32'h11);
    applyStimulus(1, 11, 32'hA1, 0, 0, 0);
    applyStimulus(1, 12, 32'hA2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fill the buffer, offer a duplicate and an over-full push, then let
    // the pipeline starve the buffer until forced drains occur.
    applyStimulus(1, 20, 32'hB0, 1, 1, 32'h101);
    applyStimulus(1, 21, 32'hB1, 1, 2, 32'h102);
    applyStimulus(1, 22, 32'hB2, 1, 3, 32'h103);
    applyStimulus(1, 23, 32'hB3, 1, 2, 32'h1FF);
    applyStimulus(1, 24, 32'hB4, 1, 4, 32'h104);
    applyStimulus(1, 25, 32'hB5, 1, 5, 32'h105);
    for (int i = 0; i < 30; i++) applyStimulus(1, AW'(16 + (i % 8)), 32'hC000 + i, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);

    // Single buffered entry under continuous pipeline writes.
    applyStimulus(1, 20, 32'hD0, 1, 6, 32'h66);
    for (int i = 0; i < 12; i++) applyStimulus(1, AW'(24 + (i % 4)), 32'hD100 + i, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-operation with three buffered entries.
    applyStimulus(1, 20, 32'hE0, 1, 3, 32'h33);
    applyStimulus(1, 21, 32'hE1, 1, 4, 32'h44);
    applyStimulus(1, 22, 32'hE2, 1, 5, 32'h55);
    applyStimulus(1, 23, 32'hE3, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset_we3", 64'(we3), 64'd0);
    checkOutput("reset_ad3", 64'(ad3), 64'd0);
    checkOutput("reset_wd3", 64'(wd3), 64'd0);
    checkOutput("reset_pipe_stall", 64'(pipe_stall), 64'd0);
    checkOutput("reset_pending_mask", 64'(pending_mask), 64'd0);
    checkOutput("reset_fifo_count", 64'(fifo_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

    // Multi-cycle result into an empty buffer with an idle pipeline.
    applyStimulus(0, 0, 0, 1, 9, 32'h42);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic with varying pipeline load; mc results are held
    // until the handshake completes.
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
      for (int i = 0; i < 700; i++) begin
        @(posedge clk);
        #1;
        pwe = ($urandom_range(0, 99) < pct);
        prd = AW'($urandom_range(0, NREGS - 1));
        if (is_pending(prd)) prd = '0;
        pwd = $urandom;
        if (!(mv && !m_accepted)) begin
          mv  = ($urandom_range(0, 1) == 1);
          mrd = AW'($urandom_range(0, (ph == 2) ? NREGS - 1 : 7));
          mwd = $urandom;
        end
        driveInputs(pwe, prd, pwd, mv, mrd, mwd);
      end
    end

    mv = 1'b0;
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
